serial_frame_tx: RTL and testbench

Parallel-in, serial-out frame transmitter: captures a WIDTH-bit word on a load strobe and shifts it out one bit per clock as start bit, data LSB first, optional parity, stop bit. It is the read-out counterpart to our flip-flop storage and serial-capture blocks. It takes a word held in registers and drives it onto a single line, so a matching receiver can rebuild it. It is built from the positive-edge D flip-flops and 2:1 mux cells already in the library.

---
 rtl/serial_frame_tx_if.sv | 14 +
 rtl/serial_frame_tx.sv | 109 ++++++++++
 tb/tb_serial_frame_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// Parallel-load / serial-out bus for serial_frame_tx: word and load strobe in,
// serial line and frame status out.
interface serial_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             ld;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (output d, ld, input tx, busy, done);
  modport slave  (input d, ld, output tx, busy, done);
endinterface

// File: rtl/serial_frame_tx.sv
// Frame transmitter: start bit, WIDTH data bits LSB first, optional even parity
// (compiled in when PARITY_EN is defined), stop bit. All outputs registered.
module serial_frame_tx #(
  parameter int unsigned WIDTH = 8
) (
  input logic              c,
  input logic              re_,
  serial_frame_tx_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
`ifdef PARITY_EN
  logic             par_q;
`endif

  // Output registers are loaded from the current state, so the line trails the
  // state by one cycle: state IDLE coincides with the stop bit on the line.
  always_ff @(posedge c or negedge re_) begin
    if (!re_) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          // busy_q still high here only on the first idle cycle after STOP
          done_q <= busy_q;
          if (bus.ld) begin
            shift_q <= bus.d;
            cnt_q   <= '0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
            state_q <= StStart;
          end
        end
        StStart: begin
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state_q <= StData;
        end
        StData: begin
          tx_q    <= shift_q[0];
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          shift_q <= shift_q >> 1;
          cnt_q   <= cnt_q + CntW'(1);
`ifdef PARITY_EN
          par_q   <= par_q ^ shift_q[0];
`endif
          if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef PARITY_EN
            state_q <= StPar;
`else
            state_q <= StStop;
`endif
          end
        end
`ifdef PARITY_EN
        StPar: begin
          tx_q    <= par_q;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state_q <= StStop;
        end
`endif
        StStop: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed + random frames checked against a queue-based model of the line.
module tb_serial_frame_tx;

  localparam int unsigned W = 8;

  logic c;
  logic re_;
  int   vectors;
  int   miscompares;
  bit   exp_q[$];

  serial_frame_tx_if #(.WIDTH(W)) bus ();

  serial_frame_tx #(.WIDTH(W)) dut (
    .c   (c),
    .re_ (re_),
    .bus (bus)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line sequence for one frame, straight from the frame format.
  task automatic build(input logic [W-1:0] w);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int b = 0; b < int'(W); b++) exp_q.push_back(w[b]);
`ifdef PARITY_EN
    exp_q.push_back(^w);
`endif
    exp_q.push_back(1'b1);
  endtask

  task automatic scramble_d();
    logic [31:0] r;
    r = $urandom;
    bus.d = r[W-1:0];
  endtask

  task automatic load(input logic [W-1:0] w);
    bus.d  = w;
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
    scramble_d();
  endtask

  // Checks a frame already accepted; optionally pokes ld mid-DATA, or chains
  // the next word so it is accepted on the edge that raises done.
  task automatic run_frame(input logic [W-1:0] w, input bit poke, input bit chain,
                           input logic [W-1:0] next_w);
    build(w);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (poke && i == 4) begin
        bus.ld = 1'b1;
        bus.d  = '1;
      end
      tick();
      bus.ld = 1'b0;
      scramble_d();
      chk($sformatf("tx[%0d] w=%0h", i, w), 32'(bus.tx), 32'(exp_q[i]));
      chk($sformatf("busy[%0d] w=%0h", i, w), 32'(bus.busy), 32'd1);
      chk($sformatf("done_low[%0d] w=%0h", i, w), 32'(bus.done), 32'd0);
    end
    if (chain) begin
      bus.d  = next_w;
      bus.ld = 1'b1;
    end
    tick();
    bus.ld = 1'b0;
    scramble_d();
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("tx_idle_after", 32'(bus.tx), 32'd1);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_tx"}, 32'(bus.tx), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r;
    vectors     = 0;
    miscompares = 0;
    re_    = 1'b0;
    bus.ld = 1'b0;
    bus.d  = '0;

    // Held in reset while ld toggles
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      bus.ld = r[0];
      bus.d  = r[W:1];
      tick();
      chk("rst_tx", 32'(bus.tx), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
    end
    bus.ld = 1'b0;
    #3 re_ = 1'b1;
    idle_check("post_rst", 2);

    // Directed frames
    load(8'hA5);
    run_frame(8'hA5, 1'b0, 1'b0, '0);
    idle_check("idle_a5", 1);
    load(8'h07);
    run_frame(8'h07, 1'b0, 1'b0, '0);
    idle_check("idle_07", 1);

    // Load while busy is ignored
    load(8'h00);
    run_frame(8'h00, 1'b1, 1'b0, '0);
    idle_check("no_second_frame", 4);

    // Back-to-back C3 then 3C, then data-hold word 5A
    load(8'hC3);
    run_frame(8'hC3, 1'b0, 1'b1, 8'h3C);
    run_frame(8'h3C, 1'b0, 1'b0, '0);
    load(8'h5A);
    run_frame(8'h5A, 1'b0, 1'b0, '0);
    idle_check("idle_5a", 1);

    // Random words, some chained
    for (int n = 0; n < 12; n++) begin
      logic [W-1:0] w;
      logic [W-1:0] w2;
      r  = $urandom;
      w  = r[W-1:0];
      w2 = r[2*W-1:W];
      load(w);
      run_frame(w, 1'b0, r[31], w2);
      if (r[31]) run_frame(w2, 1'b0, 1'b0, '0);
      idle_check("rand_idle", 1);
    end

    // Reset in the middle of DATA: immediate idle line, no done pulse
    load(8'hF0);
    tick();
    tick();
    tick();
    #2 re_ = 1'b0;
    #1;
    chk("midrst_tx", 32'(bus.tx), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    tick();
    #3 re_ = 1'b1;
    idle_check("after_midrst", 14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
